// File: rtl/aurora_pkg.sv
// Shared Aurora types.
//   ordered_sets_e  : ordered set selector driven to the TX ordered-set mux
//   chinit_state_e  : channel initialisation controller states
//   os_for_state()  : state -> ordered set decode used by the controller
package aurora_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SP   = 2'd1,
        I    = 2'd2,
        VER  = 2'd3
    } ordered_sets_e;

    typedef enum logic [2:0] {
        RESET        = 3'd0,
        INIT         = 3'd1,
        BONDING      = 3'd2,
        VERIFICATION = 3'd3,
        READY        = 3'd4
    } chinit_state_e;

    function automatic ordered_sets_e os_for_state(input chinit_state_e s);
        case (s)
            INIT:         return SP;
            BONDING:      return I;
            VERIFICATION: return VER;
            default:      return NONE;
        endcase
    endfunction

endpackage

// File: rtl/channel_init_ctrl_if.sv
// Lane status / ordered-set control bundle for channel_init_ctrl.
//   master : lane status logic side (drives lane status and verification pulses)
//   slave  : controller side (drives ordered_sets, init_finished, timeout, retry_cnt)
interface channel_init_ctrl_if #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned RETRY_W = 8
);
    import aurora_pkg::*;

    logic [LANES-1:0]   lanes_active;
    logic [LANES-1:0]   lane_aligned;
    logic [LANES-1:0]   lane_bonded;
    logic               ver_rx;
    logic               ver_err;
    ordered_sets_e      ordered_sets;
    logic               init_finished;
    logic               timeout;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        output lanes_active, lane_aligned, lane_bonded, ver_rx, ver_err,
        input  ordered_sets, init_finished, timeout, retry_cnt
    );

    modport slave (
        input  lanes_active, lane_aligned, lane_bonded, ver_rx, ver_err,
        output ordered_sets, init_finished, timeout, retry_cnt
    );

endinterface

// File: rtl/channel_init_ctrl_watchdog.sv
// Per-phase watchdog: counts cycles while en is high, cleared by clr.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear counter (phase change)
//   en         : phase is watched
//   expire     : counter has reached LIMIT-1 during a watched phase
// LIMIT == 0 disables the watchdog (expire tied low).
module phase_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (LIMIT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clr, en};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int unsigned W = $clog2(LIMIT + 1);
            logic [W-1:0] cnt;

            assign expire = en && (cnt == W'(LIMIT - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en && !expire) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/channel_init_ctrl.sv
// Aurora channel initialisation controller for an N-lane simplex channel.
// Walks RESET/INIT/BONDING/VERIFICATION/READY, qualifying lanes with a mask
// latched at RESET exit, counting verification sequences, restarting on
// alignment loss or watchdog expiry with a saturating retry counter.
//   clk           : clock
//   rst_n         : asynchronous active-low reset
//   simplex_reset : synchronous soft reset (retry_cnt held)
//   chan          : lane status in, ordered_sets/init_finished/timeout/retry_cnt out
module channel_init_ctrl
    import aurora_pkg::*;
#(
    parameter int unsigned LANES          = 4,
    parameter int unsigned VER_COUNT      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RETRY_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                simplex_reset,
    channel_init_ctrl_if.slave  chan
);

    localparam int unsigned VCW = $clog2(VER_COUNT + 1);

    chinit_state_e  state, state_nxt;
    logic [LANES-1:0] mask;
    logic [VCW-1:0] ver_cnt;
    logic all_aligned, all_bonded, any_lost, single_lane, ver_done;
    logic restart, wd_restart, wd_en, wd_clr, wd_expire;

    // Lanes outside the mask count as aligned/bonded and never as lost.
    assign all_aligned = &(chan.lane_aligned | ~mask);
    assign all_bonded  = &(chan.lane_bonded | ~mask);
    assign any_lost    = |(~chan.lane_aligned & mask);
    assign single_lane = ($countones(mask) == 1);
    assign ver_done    = chan.ver_rx && !chan.ver_err && (ver_cnt == VCW'(VER_COUNT - 1));

    assign wd_en  = (state == INIT) || (state == BONDING) || (state == VERIFICATION);
    assign wd_clr = simplex_reset || (state_nxt != state);

    phase_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Priority inside each phase: legal advance, then alignment loss, then watchdog.
    always_comb begin
        state_nxt  = state;
        restart    = 1'b0;
        wd_restart = 1'b0;
        case (state)
            RESET: begin
                if (chan.lanes_active != '0) state_nxt = INIT;
            end
            INIT: begin
                if (all_aligned) begin
                    state_nxt = single_lane ? VERIFICATION : BONDING;
                end else if (wd_expire) begin
                    state_nxt  = RESET;
                    restart    = 1'b1;
                    wd_restart = 1'b1;
                end
            end
            BONDING: begin
                if (all_bonded) begin
                    state_nxt = VERIFICATION;
                end else if (any_lost) begin
                    state_nxt = RESET;
                    restart   = 1'b1;
                end else if (wd_expire) begin
                    state_nxt  = RESET;
                    restart    = 1'b1;
                    wd_restart = 1'b1;
                end
            end
            VERIFICATION: begin
                if (ver_done) begin
                    state_nxt = READY;
                end else if (any_lost) begin
                    state_nxt = RESET;
                    restart   = 1'b1;
                end else if (wd_expire) begin
                    state_nxt  = RESET;
                    restart    = 1'b1;
                    wd_restart = 1'b1;
                end
            end
            READY: begin
                if (any_lost) begin
                    state_nxt = RESET;
                    restart   = 1'b1;
                end
            end
            default: state_nxt = RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= RESET;
            mask               <= '0;
            ver_cnt            <= '0;
            chan.ordered_sets  <= NONE;
            chan.init_finished <= 1'b0;
            chan.timeout       <= 1'b0;
            chan.retry_cnt     <= '0;
        end else if (simplex_reset) begin
            state              <= RESET;
            mask               <= '0;
            ver_cnt            <= '0;
            chan.ordered_sets  <= NONE;
            chan.init_finished <= 1'b0;
            chan.timeout       <= 1'b0;
        end else begin
            state              <= state_nxt;
            chan.ordered_sets  <= os_for_state(state_nxt);
            chan.init_finished <= (state_nxt == READY);
            chan.timeout       <= wd_restart;
            if (state == RESET && state_nxt == INIT) mask <= chan.lanes_active;
            // Counter is only meaningful while staying in VERIFICATION; zero on entry.
            if (state != VERIFICATION || state_nxt != VERIFICATION) begin
                ver_cnt <= '0;
            end else if (chan.ver_err) begin
                ver_cnt <= '0;
            end else if (chan.ver_rx) begin
                ver_cnt <= ver_cnt + 1'b1;
            end
            if (restart && chan.retry_cnt != '1) chan.retry_cnt <= chan.retry_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_channel_init_ctrl.sv
// Directed self-checking bench for channel_init_ctrl (LANES=4, VER_COUNT=4,
// TIMEOUT_CYCLES=16). A second instance with RETRY_W=2 shares the stimulus
// to exercise retry counter saturation.
module tb_channel_init_ctrl;
    import aurora_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic simplex_reset;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    channel_init_ctrl_if #(.LANES(4), .RETRY_W(8)) bus ();
    channel_init_ctrl_if #(.LANES(4), .RETRY_W(2)) bus2 ();

    assign bus2.lanes_active = bus.lanes_active;
    assign bus2.lane_aligned = bus.lane_aligned;
    assign bus2.lane_bonded  = bus.lane_bonded;
    assign bus2.ver_rx       = bus.ver_rx;
    assign bus2.ver_err      = bus.ver_err;

    channel_init_ctrl #(.LANES(4), .VER_COUNT(4), .TIMEOUT_CYCLES(16), .RETRY_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .simplex_reset(simplex_reset), .chan(bus)
    );

    channel_init_ctrl #(.LANES(4), .VER_COUNT(4), .TIMEOUT_CYCLES(16), .RETRY_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .simplex_reset(simplex_reset), .chan(bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_os(input string tag, input ordered_sets_e os, input logic fin);
        chk({tag, "_os"}, 32'(bus.ordered_sets), 32'(os));
        chk({tag, "_fin"}, 32'(bus.init_finished), 32'(fin));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n = 1'b0;
        simplex_reset = 1'b0;
        bus.lanes_active = 4'h0;
        bus.lane_aligned = 4'h0;
        bus.lane_bonded  = 4'h0;
        bus.ver_rx  = 1'b0;
        bus.ver_err = 1'b0;
        #1;
        chk_os("reset", NONE, 1'b0);
        chk("reset_timeout", 32'(bus.timeout), 32'd0);
        chk("reset_retry", 32'(bus.retry_cnt), 32'd0);
        chk("reset_retry2", 32'(bus2.retry_cnt), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_os("no_lanes_idle", NONE, 1'b0);

        // Full bring-up
        bus.lanes_active = 4'hF;
        tick();               chk_os("t1_init", SP, 1'b0);
        repeat (4) tick();    chk_os("t1_init_hold", SP, 1'b0);
        bus.lane_aligned = 4'hF;
        tick();               chk_os("t1_bonding", I, 1'b0);
        repeat (4) tick();    chk_os("t1_bond_hold", I, 1'b0);
        bus.lane_bonded = 4'hF;
        tick();               chk_os("t1_ver", VER, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.ver_rx = 1'b1;
            tick();
            chk_os("t1_ver_cnt", VER, 1'b0);
        end
        tick();               chk_os("t1_ready", NONE, 1'b1);
        chk("t1_retry", 32'(bus.retry_cnt), 32'd0);
        bus.ver_rx = 1'b0;

        // Alignment loss from READY
        repeat (3) tick();    chk_os("t5_ready_hold", NONE, 1'b1);
        bus.lane_aligned = 4'b1101;
        bus.lane_bonded  = 4'h0;
        tick();               chk_os("t5_lost", NONE, 1'b0);
        chk("t5_retry", 32'(bus.retry_cnt), 32'd1);
        tick();               chk_os("t5_reinit", SP, 1'b0);

        // Watchdog expiry in INIT
        repeat (15) tick();   chk_os("t4_pre_expire", SP, 1'b0);
        chk("t4_no_timeout_yet", 32'(bus.timeout), 32'd0);
        tick();               chk_os("t4_expired", NONE, 1'b0);
        chk("t4_timeout", 32'(bus.timeout), 32'd1);
        chk("t4_retry", 32'(bus.retry_cnt), 32'd2);
        tick();               chk_os("t4_reinit", SP, 1'b0);
        chk("t4_timeout_pulse", 32'(bus.timeout), 32'd0);

        // Alignment on the last watchdog cycle advances instead of expiring
        repeat (15) tick();
        bus.lane_aligned = 4'hF;
        tick();               chk_os("t4_late_adv", I, 1'b0);
        chk("t4_late_no_timeout", 32'(bus.timeout), 32'd0);
        chk("t4_late_retry", 32'(bus.retry_cnt), 32'd2);

        // Repeated alignment loss in BONDING: retry counts, 2-bit copy saturates
        bus.lane_aligned = 4'b1101;
        tick();               chk("sat_r3", 32'(bus.retry_cnt), 32'd3);
        tick();
        bus.lane_aligned = 4'hF;
        tick();               chk_os("sat_bond", I, 1'b0);
        bus.lane_aligned = 4'b1101;
        tick();               chk("sat_r4", 32'(bus.retry_cnt), 32'd4);
        chk("sat_r4_2bit", 32'(bus2.retry_cnt), 32'd3);
        tick();
        bus.lane_aligned = 4'hF;
        tick();
        bus.lane_aligned = 4'b1101;
        tick();               chk("sat_r5", 32'(bus.retry_cnt), 32'd5);
        chk("sat_r5_2bit", 32'(bus2.retry_cnt), 32'd3);

        // Advance beats alignment loss in BONDING
        tick();
        bus.lane_aligned = 4'hF;
        tick();               chk_os("prio_bond", I, 1'b0);
        bus.lane_aligned = 4'b1101;
        bus.lane_bonded  = 4'hF;
        tick();               chk_os("prio_adv", VER, 1'b0);
        chk("prio_retry", 32'(bus.retry_cnt), 32'd5);
        tick();               chk_os("prio_ver_lost", NONE, 1'b0);
        chk("prio_ver_retry", 32'(bus.retry_cnt), 32'd6);
        tick();
        bus.lane_aligned = 4'hF;
        bus.lane_bonded  = 4'h0;
        tick();
        tick();               chk_os("t6_in_bonding", I, 1'b0);

        // Asynchronous reset mid-BONDING
        #2 rst_n = 1'b0;
        #1;
        chk_os("t6_async", NONE, 1'b0);
        chk("t6_async_retry", 32'(bus.retry_cnt), 32'd0);
        chk("t6_async_retry2", 32'(bus2.retry_cnt), 32'd0);
        chk("t6_async_timeout", 32'(bus.timeout), 32'd0);
        tick();               chk_os("t6_held", NONE, 1'b0);

        // Single lane: INIT straight to VERIFICATION
        bus.lanes_active = 4'b0100;
        bus.lane_aligned = 4'h0;
        rst_n = 1'b1;
        tick();               chk_os("t2_init", SP, 1'b0);
        bus.lane_aligned = 4'b1011;
        bus.lane_bonded  = 4'hF;
        tick();               chk_os("t2_unmasked_only", SP, 1'b0);
        bus.lane_aligned = 4'b0100;
        bus.lanes_active = 4'hF;
        tick();               chk_os("t2_skip_bond", VER, 1'b0);
        bus.lane_aligned = 4'b0110;
        tick();               chk_os("t2_unmasked_toggle", VER, 1'b0);
        chk("t2_retry", 32'(bus.retry_cnt), 32'd0);

        // ver_err handling
        bus.ver_rx = 1'b1;
        repeat (3) tick();    chk_os("t3_rx3", VER, 1'b0);
        bus.ver_err = 1'b1;
        tick();               chk_os("t3_rx_err", VER, 1'b0);
        bus.ver_err = 1'b0;
        repeat (3) tick();    chk_os("t3_rx3_after_both", VER, 1'b0);
        bus.ver_rx  = 1'b0;
        bus.ver_err = 1'b1;
        tick();
        bus.ver_err = 1'b0;
        bus.ver_rx  = 1'b1;
        repeat (3) tick();    chk_os("t3_rx3_after_err", VER, 1'b0);
        tick();               chk_os("t3_ready", NONE, 1'b1);
        bus.ver_rx  = 1'b0;
        bus.ver_err = 1'b1;
        bus.lane_bonded = 4'h0;
        tick();               chk_os("t3_ready_ignores", NONE, 1'b1);
        bus.ver_err = 1'b0;

        // Soft reset mid-VERIFICATION
        bus.lane_aligned = 4'b0010;
        tick();               chk("t6_lost_retry", 32'(bus.retry_cnt), 32'd1);
        bus.lane_aligned = 4'hF;
        tick();               chk_os("t6_init", SP, 1'b0);
        tick();               chk_os("t6_bond", I, 1'b0);
        bus.lane_bonded = 4'hF;
        tick();               chk_os("t6_ver", VER, 1'b0);
        bus.ver_rx = 1'b1;
        repeat (2) tick();
        bus.ver_rx = 1'b0;
        simplex_reset = 1'b1;
        bus.lanes_active = 4'h0;
        tick();               chk_os("t6_soft", NONE, 1'b0);
        chk("t6_soft_retry", 32'(bus.retry_cnt), 32'd1);
        chk("t6_soft_retry2", 32'(bus2.retry_cnt), 32'd1);
        simplex_reset = 1'b0;
        repeat (3) tick();    chk_os("t6_no_lanes", NONE, 1'b0);
        bus.lanes_active = 4'hF;
        tick();               chk_os("t6_re_init", SP, 1'b0);
        tick();               chk_os("t6_re_bond", I, 1'b0);
        tick();               chk_os("t6_re_ver", VER, 1'b0);
        bus.ver_rx = 1'b1;
        repeat (3) tick();    chk_os("t6_re_rx3", VER, 1'b0);
        tick();               chk_os("t6_re_ready", NONE, 1'b1);
        chk("t6_final_retry", 32'(bus.retry_cnt), 32'd1);
        bus.ver_rx = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
